// File: rtl/processor.sv
// Multi-cycle 32-bit load/store core with internal 2048x32 instruction and data memories.
// Build option: define R0_ZERO_EN to make R0 read as zero and discard writes to it.

module processor_sram #(
   parameter int AW = 11,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          cen,
   input  logic          wen,
   input  logic          oen,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout
);
   logic [DW-1:0] mem [1<<AW];
   logic [DW-1:0] rdata;

   // NOTE: the array and read register carry no reset; resetting them would turn the RAM into flops.
   // NOTE: clocked state always uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!cen) begin
         if (!wen) mem[addr] <= din;
         else      rdata     <= mem[addr];
      end
   end

   assign dout = oen ? '0 : rdata;
endmodule

module processor #(
   parameter int DATA_W = 32,
   parameter int MEM_AW = 11,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              loading,
   input  logic              im_cen_load,
   input  logic              im_wen_load,
   input  logic              im_oen_load,
   input  logic [MEM_AW-1:0] im_addr_load,
   input  logic [DATA_W-1:0] im_datain_load,
   input  logic              dm_cen_load,
   input  logic              dm_wen_load,
   input  logic              dm_oen_load,
   input  logic [MEM_AW-1:0] dm_addr_load,
   input  logic [DATA_W-1:0] dm_datain_load,
   output logic [DATA_W-1:0] dbg_pc,
   output logic [DATA_W-1:0] dbg_ir
);
   localparam int REG_N = 1 << REG_AW;
   localparam int IMM_W = 15;

   localparam logic [6:0] OP_MOVA = 7'b1000000;
   localparam logic [6:0] OP_ADD  = 7'b0000010;
   localparam logic [6:0] OP_SUB  = 7'b0000101;
   localparam logic [6:0] OP_AND  = 7'b0001000;
   localparam logic [6:0] OP_OR   = 7'b0001001;
   localparam logic [6:0] OP_XOR  = 7'b0001010;
   localparam logic [6:0] OP_NOT  = 7'b0001011;
   localparam logic [6:0] OP_ADI  = 7'b0100010;
   localparam logic [6:0] OP_SBI  = 7'b0100101;
   localparam logic [6:0] OP_ANI  = 7'b0101000;
   localparam logic [6:0] OP_ORI  = 7'b0101001;
   localparam logic [6:0] OP_XRI  = 7'b0101010;
   localparam logic [6:0] OP_MOVB = 7'b0001100;
   localparam logic [6:0] OP_LSR  = 7'b0001101;
   localparam logic [6:0] OP_LSL  = 7'b0001110;
   localparam logic [6:0] OP_LD   = 7'b0010000;
   localparam logic [6:0] OP_ST   = 7'b0100000;
   localparam logic [6:0] OP_SLT  = 7'b1100101;
   localparam logic [6:0] OP_JMR  = 7'b1110000;
   localparam logic [6:0] OP_BZ   = 7'b1100000;
   localparam logic [6:0] OP_BNZ  = 7'b1001000;
   localparam logic [6:0] OP_JMP  = 7'b1101000;
   localparam logic [6:0] OP_JML  = 7'b0110000;

   typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_WB} state_t;

   state_t state, state_nxt;
   logic [DATA_W-1:0] pc, ir, a_q, b_q;
   logic [DATA_W-1:0] rf [REG_N];

   logic              im_cen, im_wen, im_oen, dm_cen, dm_wen, dm_oen;
   logic [MEM_AW-1:0] im_addr, dm_addr;
   logic [DATA_W-1:0] im_din, dm_din, im_dout, dm_dout;

   logic [6:0]        op;
   logic [REG_AW-1:0] dr;
   logic [4:0]        sh;
   logic [DATA_W-1:0] imm_se, imm_ze, pc_inc, pc_br;
   logic [DATA_W-1:0] rd_a, rd_b, alu_y, pc_exec, rf_wdata;
   logic              exec_we, rf_we, core_dm_wen;
   logic [MEM_AW-1:0] core_dm_addr;

   assign op     = ir[31:25];
   assign dr     = ir[24:20];
   assign sh     = ir[4:0];
   assign imm_se = {{(DATA_W-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
   assign imm_ze = {{(DATA_W-IMM_W){1'b0}}, ir[IMM_W-1:0]};
   assign pc_inc = pc + DATA_W'(1);
   assign pc_br  = pc + imm_se;
   assign dbg_pc = pc;
   assign dbg_ir = ir;

   // Loading hands both memories to the external port; otherwise the core owns them.
   always_comb begin
      if (loading) begin
         im_cen = im_cen_load;  im_wen = im_wen_load;  im_oen = im_oen_load;
         im_addr = im_addr_load; im_din = im_datain_load;
         dm_cen = dm_cen_load;  dm_wen = dm_wen_load;  dm_oen = dm_oen_load;
         dm_addr = dm_addr_load; dm_din = dm_datain_load;
      end else begin
         im_cen = 1'b0; im_wen = 1'b1; im_oen = 1'b0;
         im_addr = pc[MEM_AW-1:0]; im_din = '0;
         dm_cen = 1'b0; dm_wen = core_dm_wen; dm_oen = 1'b0;
         dm_addr = core_dm_addr; dm_din = a_q;
      end
   end

   processor_sram #(.AW(MEM_AW), .DW(DATA_W)) u_im (
      .clk(clk), .cen(im_cen), .wen(im_wen), .oen(im_oen),
      .addr(im_addr), .din(im_din), .dout(im_dout)
   );

   processor_sram #(.AW(MEM_AW), .DW(DATA_W)) u_dm (
      .clk(clk), .cen(dm_cen), .wen(dm_wen), .oen(dm_oen),
      .addr(dm_addr), .din(dm_din), .dout(dm_dout)
   );

   // Operands are read in DECODE straight from the IM output, in parallel with the IR load.
   always_comb begin
      rd_a = rf[im_dout[19:15]];
      rd_b = rf[im_dout[14:10]];
`ifdef R0_ZERO_EN
      if (im_dout[19:15] == '0) rd_a = '0;
      if (im_dout[14:10] == '0) rd_b = '0;
`endif
   end

   always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      alu_y   = '0;
      exec_we = 1'b0;
      pc_exec = pc_inc;
      case (op)
         OP_MOVA: begin alu_y = a_q;             exec_we = 1'b1; end
         OP_ADD:  begin alu_y = a_q + b_q;       exec_we = 1'b1; end
         OP_SUB:  begin alu_y = a_q - b_q;       exec_we = 1'b1; end
         OP_AND:  begin alu_y = a_q & b_q;       exec_we = 1'b1; end
         OP_OR:   begin alu_y = a_q | b_q;       exec_we = 1'b1; end
         OP_XOR:  begin alu_y = a_q ^ b_q;       exec_we = 1'b1; end
         OP_NOT:  begin alu_y = ~a_q;            exec_we = 1'b1; end
         OP_ADI:  begin alu_y = a_q + imm_se;    exec_we = 1'b1; end
         OP_SBI:  begin alu_y = a_q - imm_se;    exec_we = 1'b1; end
         OP_ANI:  begin alu_y = a_q & imm_ze;    exec_we = 1'b1; end
         OP_ORI:  begin alu_y = a_q | imm_ze;    exec_we = 1'b1; end
         OP_XRI:  begin alu_y = a_q ^ imm_ze;    exec_we = 1'b1; end
         OP_MOVB: begin alu_y = b_q;             exec_we = 1'b1; end
         OP_LSR:  begin alu_y = a_q >> sh;       exec_we = 1'b1; end
         OP_LSL:  begin alu_y = a_q << sh;       exec_we = 1'b1; end
         OP_SLT:  begin
            alu_y   = ($signed(a_q) < $signed(b_q)) ? DATA_W'(1) : '0;
            exec_we = 1'b1;
         end
         OP_JMR:  pc_exec = a_q;
         OP_BZ:   if (a_q == '0) pc_exec = pc_br;
         OP_BNZ:  if (a_q != '0) pc_exec = pc_br;
         OP_JMP:  pc_exec = pc_br;
         OP_JML:  begin alu_y = pc_inc; exec_we = 1'b1; pc_exec = pc_br; end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        state <= S_FETCH;
      else if (!loading) state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_FETCH:  state_nxt = S_DECODE;
         S_DECODE: state_nxt = S_EXEC;
         S_EXEC:   state_nxt = (op == OP_LD) ? S_WB : S_FETCH;
         S_WB:     state_nxt = S_FETCH;
         default:  state_nxt = S_FETCH;
      endcase
   end

   // LD reads DM at A in EXEC and the registered data is written back in WB.
   always_comb begin
      core_dm_wen  = 1'b1;
      core_dm_addr = a_q[MEM_AW-1:0];
      rf_we        = 1'b0;
      rf_wdata     = alu_y;
      case (state)
         S_EXEC: begin
            rf_we = exec_we;
            if (op == OP_ST) begin
               core_dm_wen  = 1'b0;
               core_dm_addr = b_q[MEM_AW-1:0];
            end
         end
         S_WB: begin
            rf_we    = 1'b1;
            rf_wdata = dm_dout;
         end
         default: ;
      endcase
`ifdef R0_ZERO_EN
      if (dr == '0) rf_we = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc  <= '0;
         ir  <= '0;
         a_q <= '0;
         b_q <= '0;
      end else if (!loading) begin
         case (state)
            S_DECODE: begin
               ir  <= im_dout;
               a_q <= rd_a;
               b_q <= rd_b;
            end
            S_EXEC:  if (op != OP_LD) pc <= pc_exec;
            S_WB:    pc <= pc_inc;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_N; i++) rf[i] <= '0;
      end else if (!loading && rf_we) begin
         rf[dr] <= rf_wdata;
      end
   end
endmodule

// File: tb/tb_processor.sv
// Directed bench for processor: preloads a program through the loading port and checks
// registers, DM, dbg_pc and dbg_ir after each instruction, then stall and mid-EXEC reset.

module tb_processor;
   logic        clk = 1'b0;
   logic        rst_n, loading;
   logic        im_cen_load, im_wen_load, im_oen_load;
   logic [10:0] im_addr_load;
   logic [31:0] im_datain_load;
   logic        dm_cen_load, dm_wen_load, dm_oen_load;
   logic [10:0] dm_addr_load;
   logic [31:0] dm_datain_load;
   logic [31:0] dbg_pc, dbg_ir;

   int total = 0;
   int bad   = 0;

   processor dut (
      .clk(clk), .rst_n(rst_n), .loading(loading),
      .im_cen_load(im_cen_load), .im_wen_load(im_wen_load), .im_oen_load(im_oen_load),
      .im_addr_load(im_addr_load), .im_datain_load(im_datain_load),
      .dm_cen_load(dm_cen_load), .dm_wen_load(dm_wen_load), .dm_oen_load(dm_oen_load),
      .dm_addr_load(dm_addr_load), .dm_datain_load(dm_datain_load),
      .dbg_pc(dbg_pc), .dbg_ir(dbg_ir)
   );

   always #5 clk = ~clk;

   localparam logic [6:0] OP_MOVA = 7'b1000000, OP_ADD = 7'b0000010, OP_SUB = 7'b0000101;
   localparam logic [6:0] OP_AND  = 7'b0001000, OP_OR  = 7'b0001001, OP_XOR = 7'b0001010;
   localparam logic [6:0] OP_NOT  = 7'b0001011, OP_ADI = 7'b0100010, OP_SBI = 7'b0100101;
   localparam logic [6:0] OP_ANI  = 7'b0101000, OP_ORI = 7'b0101001, OP_XRI = 7'b0101010;
   localparam logic [6:0] OP_MOVB = 7'b0001100, OP_LSR = 7'b0001101, OP_LSL = 7'b0001110;
   localparam logic [6:0] OP_LD   = 7'b0010000, OP_ST  = 7'b0100000, OP_SLT = 7'b1100101;
   localparam logic [6:0] OP_JMR  = 7'b1110000, OP_BZ  = 7'b1100000, OP_BNZ = 7'b1001000;
   localparam logic [6:0] OP_JMP  = 7'b1101000, OP_JML = 7'b0110000, OP_BAD = 7'b1111111;

   typedef struct {
      logic [31:0] ins;
      int          addr;
      int          ncyc;
      bit          is_dm;
      int          idx;
      logic [31:0] val;
      logic [31:0] pc;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [31:0] enc_r(input logic [6:0] op, input int dr, input int sa, input int sb);
      return {op, dr[4:0], sa[4:0], sb[4:0], 10'b0};
   endfunction

   function automatic logic [31:0] enc_i(input logic [6:0] op, input int dr, input int sa, input int imm);
      return {op, dr[4:0], sa[4:0], imm[14:0]};
   endfunction

   function automatic void add(input logic [31:0] ins, input int addr, input int ncyc,
                               input bit is_dm, input int idx, input logic [31:0] val,
                               input logic [31:0] pc);
      vec_t v;
      v.ins = ins; v.addr = addr; v.ncyc = ncyc; v.is_dm = is_dm;
      v.idx = idx; v.val = val; v.pc = pc;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic im_write(input logic [10:0] a, input logic [31:0] d);
      @(negedge clk);
      im_cen_load = 1'b0; im_wen_load = 1'b0; im_addr_load = a; im_datain_load = d;
      @(negedge clk);
      im_cen_load = 1'b1; im_wen_load = 1'b1;
   endtask

   task automatic dm_write(input logic [10:0] a, input logic [31:0] d);
      @(negedge clk);
      dm_cen_load = 1'b0; dm_wen_load = 1'b0; dm_addr_load = a; dm_datain_load = d;
      @(negedge clk);
      dm_cen_load = 1'b1; dm_wen_load = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; loading = 1'b1;
      im_cen_load = 1'b1; im_wen_load = 1'b1; im_oen_load = 1'b1;
      im_addr_load = '0;  im_datain_load = '0;
      dm_cen_load = 1'b1; dm_wen_load = 1'b1; dm_oen_load = 1'b1;
      dm_addr_load = '0;  dm_datain_load = '0;

      //   instruction                       addr cyc dm idx value          pc
      add(enc_i(OP_ADI, 1, 0, 5),              0, 3, 0, 1,  32'h0000_0005, 32'd1);
      add(enc_i(OP_ADI, 2, 0, -3),             1, 3, 0, 2,  32'hFFFF_FFFD, 32'd2);
      add(enc_r(OP_ADD, 3, 1, 2),              2, 3, 0, 3,  32'h0000_0002, 32'd3);
      add(enc_r(OP_SUB, 4, 1, 2),              3, 3, 0, 4,  32'h0000_0008, 32'd4);
      add(enc_r(OP_SLT, 5, 2, 1),              4, 3, 0, 5,  32'h0000_0001, 32'd5);
      add(enc_i(OP_JMP, 0, 0, 5),              5, 3, 0, 0,  32'h0000_0000, 32'd10);
      add(enc_i(OP_BZ,  0, 0, -1),            10, 3, 0, 0,  32'h0000_0000, 32'd9);
      add(enc_i(OP_JMP, 0, 0, 2),              9, 3, 0, 0,  32'h0000_0000, 32'd11);
      add(enc_i(OP_BNZ, 0, 0, -1),            11, 3, 0, 0,  32'h0000_0000, 32'd12);
      add(enc_i(OP_BNZ, 0, 1, 8),             12, 3, 0, 1,  32'h0000_0005, 32'd20);
      add(enc_i(OP_JML, 31, 0, 4),            20, 3, 0, 31, 32'h0000_0015, 32'd24);
      add(enc_i(OP_ADI, 1, 0, 7),             24, 3, 0, 1,  32'h0000_0007, 32'd25);
      add(enc_r(OP_LD,  6, 1, 0),             25, 4, 0, 6,  32'hDEAD_BEEF, 32'd26);
      add(enc_i(OP_ADI, 2, 0, 9),             26, 3, 0, 2,  32'h0000_0009, 32'd27);
      add(enc_r(OP_ST,  0, 6, 2),             27, 3, 1, 9,  32'hDEAD_BEEF, 32'd28);
      add(enc_i(OP_ADI, 19, 0, 'h800),        28, 3, 0, 19, 32'h0000_0800, 32'd29);
      add(enc_r(OP_ST,  0, 1, 19),            29, 3, 1, 0,  32'h0000_0007, 32'd30);
      add(enc_i(OP_ADI, 1, 0, 1),             30, 3, 0, 1,  32'h0000_0001, 32'd31);
      add(enc_i(OP_LSL, 7, 1, 4),             31, 3, 0, 7,  32'h0000_0010, 32'd32);
      add(enc_i(OP_ADI, 8, 0, 1),             32, 3, 0, 8,  32'h0000_0001, 32'd33);
      add(enc_i(OP_LSL, 8, 8, 31),            33, 3, 0, 8,  32'h8000_0000, 32'd34);
      add(enc_i(OP_LSR, 9, 8, 31),            34, 3, 0, 9,  32'h0000_0001, 32'd35);
      add(enc_i(OP_SBI, 10, 0, 1),            35, 3, 0, 10, 32'hFFFF_FFFF, 32'd36);
      add(enc_i(OP_ANI, 11, 10, 'h7FFF),      36, 3, 0, 11, 32'h0000_7FFF, 32'd37);
      add(enc_i(OP_ORI, 12, 0, 'h4000),       37, 3, 0, 12, 32'h0000_4000, 32'd38);
      add(enc_r(OP_XOR, 13, 10, 8),           38, 3, 0, 13, 32'h7FFF_FFFF, 32'd39);
      add(enc_r(OP_NOT, 14, 1, 0),            39, 3, 0, 14, 32'hFFFF_FFFE, 32'd40);
      add(enc_r(OP_MOVB, 15, 0, 8),           40, 3, 0, 15, 32'h8000_0000, 32'd41);
      add(enc_r(OP_SLT, 16, 8, 0),            41, 3, 0, 16, 32'h0000_0001, 32'd42);
      add(enc_r(OP_MOVA, 17, 3, 0),           42, 3, 0, 17, 32'h0000_0002, 32'd43);
      add(enc_r(OP_AND, 20, 10, 4),           43, 3, 0, 20, 32'h0000_0008, 32'd44);
      add(enc_r(OP_OR,  21, 3, 4),            44, 3, 0, 21, 32'h0000_000A, 32'd45);
      add(enc_i(OP_XRI, 22, 10, 'hFF),        45, 3, 0, 22, 32'hFFFF_FF00, 32'd46);
      add(enc_i(OP_ADI, 18, 0, 50),           46, 3, 0, 18, 32'h0000_0032, 32'd47);
      add(enc_r(OP_JMR, 0, 18, 0),            47, 3, 0, 18, 32'h0000_0032, 32'd50);
      add(enc_r(OP_BAD, 1, 0, 0),             50, 3, 0, 1,  32'h0000_0001, 32'd51);

      #1;
      check("reset pc", dbg_pc, 32'h0);
      check("reset ir", dbg_ir, 32'h0);

      // Memories are loaded while the core is also held in reset.
      dm_write(11'd7, 32'hDEAD_BEEF);
      foreach (vecs[i]) begin
         vec_t v;
         v = vecs[i];
         im_write(v.addr[10:0], v.ins);
      end
      im_write(11'd51, enc_i(OP_ADI, 23, 0, 3));
      im_write(11'd52, enc_i(OP_ADI, 24, 0, 1));

      @(negedge clk); loading = 1'b0;
      @(negedge clk); rst_n = 1'b1;

      foreach (vecs[i]) begin
         vec_t        v;
         logic [31:0] act;
         v = vecs[i];
         repeat (v.ncyc) @(posedge clk);
         #1;
         act = v.is_dm ? dut.u_dm.mem[v.idx[10:0]] : dut.rf[v.idx[4:0]];
         check($sformatf("v%0d value", i), act, v.val);
         check($sformatf("v%0d pc", i), dbg_pc, v.pc);
         check($sformatf("v%0d ir", i), dbg_ir, v.ins);
      end

      // Stall with the core in DECODE of IM[51]: nothing may move for 10 cycles.
      @(posedge clk);
      @(negedge clk); loading = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("stall pc", dbg_pc, 32'd51);
      check("stall ir", dbg_ir, enc_r(OP_BAD, 1, 0, 0));
      check("stall r23", dut.rf[23], 32'h0);
      @(negedge clk); loading = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("resume pc", dbg_pc, 32'd52);
      check("resume r23", dut.rf[23], 32'h3);

      // Reset asserted in the middle of EXEC of IM[52].
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b0;
      #1;
      check("midreset pc", dbg_pc, 32'h0);
      check("midreset ir", dbg_ir, 32'h0);
      check("midreset r1", dut.rf[1], 32'h0);
      check("midreset r23", dut.rf[23], 32'h0);
      check("midreset r24", dut.rf[24], 32'h0);
      check("midreset r31", dut.rf[31], 32'h0);
      @(negedge clk); rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("restart pc", dbg_pc, 32'd1);
      check("restart r1", dut.rf[1], 32'h5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
